// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memop codes, the data
// segment selector, port identifiers and the response-phase state encoding.
package dmem_arbiter_pkg;

  localparam logic [2:0]  MEMOP_BYTE = 3'b000;
  localparam logic [2:0]  MEMOP_HALF = 3'b001;
  localparam logic [2:0]  MEMOP_WORD = 3'b010;

  localparam logic [11:0] SEG_DATA   = 12'h001;

  typedef enum logic {PORT_CPU, PORT_VGA} arb_port_t;

  typedef enum logic {ST_IDLE, ST_DATA} arb_state_t;

  // Data memory only sees the in-segment offset of a byte address.
  function automatic logic [31:0] seg_offset(input logic [31:0] addr);
    return {12'b0, addr[19:0]};
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_timer.sv
// Saturating wait counter for the fetcher. It counts cycles the fetcher has
// been requesting without a grant and flags when CPU priority must yield.
module arb_starve_timer #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic v_req,
  input  logic v_gnt,
  output logic starved
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_q;
  logic [7:0] wait_d;

  // Clear whenever the fetcher is served or stops asking, otherwise count up and hold at 255
  always_comb begin
    wait_d = wait_q;
    if (!v_req || v_gnt) begin
      wait_d = 8'd0;
    end else if (wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Wait counter register with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign starved = (wait_q >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store unit and the
// VGA line fetcher. CPU has fixed priority until the fetcher has waited long
// enough; out-of-segment accesses are granted but answered with an error.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [11:0] DATA_SEG     = SEG_DATA,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [2:0]  VGA_OP       = MEMOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_op,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        v_req,
  input  logic [31:0] v_addr,
  output logic        v_gnt,
  output logic        v_rvalid,
  output logic [31:0] v_rdata,
  output logic        v_err,
  output logic [31:0] m_addr,
  output logic [2:0]  m_op,
  output logic        m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  arb_state_t state_q, state_d;
  arb_port_t  pend_port_q, pend_port_d;
  logic       pend_err_q, pend_err_d;
  logic       pend_read_q, pend_read_d;

  logic starved;
  logic cSegOk;
  logic vSegOk;
  logic respActive;
  logic respCpu;
  logic respVga;

  assign cSegOk = (c_addr[31:20] == DATA_SEG);
  assign vSegOk = (v_addr[31:20] == DATA_SEG);

  arb_starve_timer #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .v_req  (v_req),
    .v_gnt  (v_gnt),
    .starved(starved)
  );

  // Pick this cycle's winner and steer its fields onto the memory port; nothing is granted while in reset
  always_comb begin
    c_gnt   = 1'b0;
    v_gnt   = 1'b0;
    m_addr  = 32'd0;
    m_op    = 3'd0;
    m_we    = 1'b0;
    m_wdata = 32'd0;
    if (reset) begin
      if (c_req && !(v_req && starved)) begin
        c_gnt   = 1'b1;
        m_addr  = seg_offset(c_addr);
        m_op    = c_op;
        m_we    = c_we && cSegOk;
        m_wdata = c_wdata;
      end else if (v_req) begin
        v_gnt   = 1'b1;
        m_addr  = seg_offset(v_addr);
        m_op    = VGA_OP;
      end
    end
  end

  // Tag the next cycle's response: any granted read, or a write that hit outside the segment
  always_comb begin
    state_d     = ST_IDLE;
    pend_port_d = pend_port_q;
    pend_err_d  = pend_err_q;
    pend_read_d = pend_read_q;
    if (c_gnt && (!c_we || !cSegOk)) begin
      state_d     = ST_DATA;
      pend_port_d = PORT_CPU;
      pend_err_d  = !cSegOk;
      pend_read_d = !c_we;
    end else if (v_gnt) begin
      state_d     = ST_DATA;
      pend_port_d = PORT_VGA;
      pend_err_d  = !vSegOk;
      pend_read_d = 1'b1;
    end
  end

  // Response tag register; a response owed across a reset is discarded
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_port_q <= PORT_CPU;
      pend_err_q  <= 1'b0;
      pend_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_port_q <= pend_port_d;
      pend_err_q  <= pend_err_d;
      pend_read_q <= pend_read_d;
    end
  end

  assign respActive = reset && (state_q == ST_DATA);
  assign respCpu    = respActive && (pend_port_q == PORT_CPU);
  assign respVga    = respActive && (pend_port_q == PORT_VGA);

  assign busy     = respActive;
  assign c_rvalid = respCpu && pend_read_q;
  assign c_err    = respCpu && pend_err_q;
  assign c_rdata  = (respCpu && !pend_err_q) ? m_rdata : 32'd0;
  assign v_rvalid = respVga && pend_read_q;
  assign v_err    = respVga && pend_err_q;
  assign v_rdata  = (respVga && !pend_err_q) ? m_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter. A reference model decides
// each cycle's winner from the arbitration rules and queues the expected
// response; a separate monitor compares every response-phase output.
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 8;

  typedef struct {
    int   cyc;
    logic port;
    logic err;
    logic rd;
  } rsp_t;

  logic        clock = 1'b1;
  logic        reset;
  logic        c_req, c_we;
  logic [2:0]  c_op;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        v_req;
  logic [31:0] v_addr;
  logic        v_gnt, v_rvalid, v_err;
  logic [31:0] v_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_op;
  logic        m_we, busy;

  int   nChecks = 0;
  int   nErrors = 0;
  int   cyc = 0;
  int   modelWait = 0;
  logic lastC = 1'b0;
  logic lastV = 1'b0;
  logic dutVgnt;
  rsp_t sb[$];

  rsp_t monE;
  logic monHave;

  dmem_arbiter #(
    .DATA_SEG    (12'h001),
    .STARVE_LIMIT(STARVE_LIMIT),
    .VGA_OP      (3'b010)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_op    (c_op),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_gnt   (c_gnt),
    .c_rvalid(c_rvalid),
    .c_rdata (c_rdata),
    .c_err   (c_err),
    .v_req   (v_req),
    .v_addr  (v_addr),
    .v_gnt   (v_gnt),
    .v_rvalid(v_rvalid),
    .v_rdata (v_rdata),
    .v_err   (v_err),
    .m_addr  (m_addr),
    .m_op    (m_op),
    .m_we    (m_we),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model of one address phase, evaluated at the negedge with inputs stable
  task automatic modelCycle();
    logic winC, winV, segC, segV;
    rsp_t e;
    segC = (c_addr[31:20] == 12'h001);
    segV = (v_addr[31:20] == 12'h001);
    winC = reset && c_req && !(v_req && modelWait >= STARVE_LIMIT);
    winV = reset && v_req && !winC;
    dutVgnt = v_gnt;
    checkOutput("c_gnt", c_gnt, winC);
    checkOutput("v_gnt", v_gnt, winV);
    checkOutput("m_addr", m_addr, winC ? {12'h000, c_addr[19:0]} : winV ? {12'h000, v_addr[19:0]} : 32'd0);
    checkOutput("m_op", m_op, winC ? c_op : winV ? 3'b010 : 3'b000);
    checkOutput("m_we", m_we, winC && c_we && segC);
    if (winC) checkOutput("m_wdata", m_wdata, c_wdata);
    if (winC && (!c_we || !segC)) begin
      e.cyc = cyc + 1; e.port = 1'b0; e.err = !segC; e.rd = !c_we;
      sb.push_back(e);
    end else if (winV) begin
      e.cyc = cyc + 1; e.port = 1'b1; e.err = !segV; e.rd = 1'b1;
      sb.push_back(e);
    end
    if (!reset || !v_req || winV) modelWait = 0;
    else if (modelWait < 255) modelWait++;
    lastC = winC;
    lastV = winV;
  endtask

  // Drive one cycle of inputs just after a posedge, check at the negedge, return just after the next posedge
  task automatic applyStimulus(input logic rst, input logic cr, input logic cw, input logic [2:0] co,
                               input logic [31:0] ca, input logic [31:0] cwd, input logic vr,
                               input logic [31:0] va, input logic [31:0] md);
    reset = rst; c_req = cr; c_we = cw; c_op = co; c_addr = ca; c_wdata = cwd;
    v_req = vr; v_addr = va; m_rdata = md;
    if (!rst) sb.delete();
    @(negedge clock);
    modelCycle();
    @(posedge clock);
    #1;
  endtask

  // Response monitor: compares every data-phase output against the scoreboard head
  always @(negedge clock) begin
    #2;
    monHave = 1'b0;
    monE.cyc = 0; monE.port = 1'b0; monE.err = 1'b0; monE.rd = 1'b0;
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      monE = sb.pop_front();
      monHave = 1'b1;
      checkOutput("rsp_cycle", monE.cyc, cyc);
    end
    checkOutput("busy", busy, monHave);
    checkOutput("c_rvalid", c_rvalid, monHave && !monE.port && monE.rd);
    checkOutput("c_err", c_err, monHave && !monE.port && monE.err);
    checkOutput("c_rdata", c_rdata, (monHave && !monE.port && !monE.err) ? m_rdata : 32'd0);
    checkOutput("v_rvalid", v_rvalid, monHave && monE.port && monE.rd);
    checkOutput("v_err", v_err, monHave && monE.port && monE.err);
    checkOutput("v_rdata", v_rdata, (monHave && monE.port && !monE.err) ? m_rdata : 32'd0);
  end

  initial begin
    logic        rCr, rCw, rVr, rRst;
    logic [2:0]  rCo;
    logic [31:0] rCa, rCwd, rVa;
    rCr = 0; rCw = 0; rVr = 0; rCo = 0; rCa = 0; rCwd = 0; rVa = 0;

    $display("[TB] reset with both requesters active");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, 3'b010, 32'h0010_0100, 0, 1, 32'h0010_0200, 32'h1111_1111);
    applyStimulus(1, 1, 0, 3'b010, 32'h0010_0100, 0, 1, 32'h0010_0200, 32'h2222_2222);

    $display("[TB] single CPU read");
    applyStimulus(1, 1, 0, 3'b010, 32'h0010_0040, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'hDEAD_BEEF);

    $display("[TB] starvation with continuous requests");
    for (int i = 0; i < 27; i++) begin
      applyStimulus(1, 1, 0, 3'b010, 32'h0010_0300, 0, 1, 32'h0010_0400, $urandom);
      checkOutput("starve_pattern", dutVgnt, (i % 9) == 8);
    end
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, $urandom);

    $display("[TB] out-of-segment accesses");
    applyStimulus(1, 1, 1, 3'b010, 32'h0020_0000, 32'hCAFE_F00D, 0, 0, 32'h5555_5555);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 1, 32'h0020_0000, 32'h6666_6666);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h7777_7777);

    $display("[TB] back-to-back grants");
    applyStimulus(1, 1, 0, 3'b010, 32'h0010_0010, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 1, 32'h0010_0020, 32'hA1A1_A1A1);
    applyStimulus(1, 1, 1, 3'b010, 32'h0010_0030, 32'h1234_5678, 0, 0, 32'hB2B2_B2B2);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'hC3C3_C3C3);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'hD4D4_D4D4);

    $display("[TB] reset while a read is outstanding");
    applyStimulus(1, 1, 0, 3'b010, 32'h0010_0050, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 0, 32'hEEEE_EEEE);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0F0F_0F0F);

    $display("[TB] randomised traffic");
    lastC = 1'b1; lastV = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!rCr || lastC) begin
        rCr  = ($urandom_range(0, 99) < 70);
        rCw  = $urandom_range(0, 1);
        rCo  = 3'($urandom_range(0, 7));
        rCa  = {($urandom_range(0, 9) == 0) ? 12'h002 : 12'h001, 20'($urandom)};
        rCwd = $urandom;
      end
      if (!rVr || lastV) begin
        rVr = ($urandom_range(0, 99) < 60);
        rVa = {($urandom_range(0, 9) == 0) ? 12'h003 : 12'h001, 20'($urandom)};
      end
      rRst = ($urandom_range(0, 99) != 0);
      applyStimulus(rRst, rCr, rCw, rCo, rCa, rCwd, rVr, rVa, $urandom);
    end
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, $urandom);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data-memory port between the CPU load/store interface and the VGA line fetcher. Sits between `cpu`/VGA and `data_mem`. Owns the only drive of the memory address/op/write-enable. The CPU has fixed priority, bounded by a starvation timer that guarantees the fetcher a grant. Accesses outside the data segment are rejected with an error pulse.

## Interface
Parameters:
- `DATA_SEG`, 12'h001: value of `addr[31:20]` that selects data memory.
- `STARVE_LIMIT`, 8: fetcher wait cycles before it overrides CPU priority. Legal range 1..255.
- `VGA_OP`, 3'b010: memop used for every fetcher access (word).

Ports:
- `clock`, in, 1: single clock; all state on posedge.
- `reset`, in, 1: synchronous, active-low.
- `c_req`, in, 1: CPU access request.
- `c_we`, in, 1: CPU write.
- `c_op`, in, 3: CPU memop, data_mem encoding.
- `c_addr`, in, 32: CPU byte address.
- `c_wdata`, in, 32: CPU write data.
- `c_gnt`, out, 1: CPU address phase accepted this cycle.
- `c_rvalid`, out, 1: CPU read data valid.
- `c_rdata`, out, 32: CPU read data.
- `c_err`, out, 1: CPU out-of-segment access completed.
- `v_req`, in, 1: fetcher read request. The fetcher is read-only.
- `v_addr`, in, 32: fetcher byte address.
- `v_gnt`, out, 1: fetcher address phase accepted.
- `v_rvalid`, out, 1: fetcher read data valid.
- `v_rdata`, out, 32: fetcher read data.
- `v_err`, out, 1: fetcher out-of-segment access.
- `m_addr`, out, 32: memory address, `{12'b0, addr[19:0]}` of the winner.
- `m_op`, out, 3: memory op.
- `m_we`, out, 1: memory write enable.
- `m_wdata`, out, 32: memory write data.
- `m_rdata`, in, 32: memory read data, valid one cycle after the address phase.
- `busy`, out, 1: a read data phase is pending this cycle.

## Operation
- **Address phase**
  - At most one grant per cycle.
  - A requester holds req/addr/op/wdata stable until it sees gnt.
  - Back-to-back grants are allowed every cycle.
- **Arbitration**
  - If both request, the CPU wins, unless `wait_cnt >= STARVE_LIMIT`; in that case the fetcher wins.
  - A lone requester always wins.
- **`wait_cnt`** (8 bits)
  - Increments on each cycle with `v_req && !v_gnt`, saturating at 255.
  - Clears on `v_gnt`, and when `v_req == 0`.
- **Memory drive**
  - Winner's fields are muxed onto the `m_*` outputs.
  - Fetcher drives `m_op = VGA_OP` and `m_we = 0`.
  - With no winner: `m_we = 0`, `m_addr = 0`, `m_op = 0`.
- **Segment check**
  - If `addr[31:20] != DATA_SEG`, the grant is still given, but `m_we` is forced to 0.
  - The next cycle pulses `x_err = 1` with `x_rdata = 0`.
  - For a read, `x_rvalid` pulses with `x_err`.
  - For a write, `x_rvalid` stays low and only `x_err` pulses.
- **Data phase**
  - A registered tag (`pend_valid`, `pend_port`, `pend_err`) is set on each granted read and on each err write.
  - Next cycle, the tagged port's `rvalid`/`err` pulse for exactly one cycle.
  - `rdata` = `m_rdata`, or 0 on err; the other port's `rdata` is 0.
  - Valid writes produce no response.
- **Reset**
  - Registered outputs and internal state clear: `c_rvalid`, `v_rvalid`, `c_err`, `v_err`, `c_rdata`, `v_rdata`, `busy`, `wait_cnt`, `pend_*` all 0.
  - `c_gnt`/`v_gnt` and `m_*` are forced 0 while reset is low.
  - A read granted in the cycle before reset falls has its response dropped.

## Timing
- `gnt` and `m_*` are combinational from the req inputs and `wait_cnt` in the same cycle; no registered delay.
- Read latency is exactly 1 cycle: `gnt` in cycle N gives `rvalid` in N+1.
- `busy` equals `pend_valid`.
- Simultaneous read response (for an N-1 grant) and new grant in cycle N are both allowed; the response port can differ from the grant port.
- Starvation bound: a continuously requesting fetcher is granted within `STARVE_LIMIT + 1` cycles.
- FSM: two states, IDLE (no pending data) and DATA (response this cycle).
  - IDLE→DATA on a granted read or err write.
  - DATA→DATA on another such grant.
  - DATA→IDLE otherwise.

## Structure
- Shared package (common): memop codes (`MEMOP_WORD = 3'b010`), the `DATA` segment constant feeding `DATA_SEG`, and `typedef enum logic {PORT_CPU, PORT_VGA} arb_port_t`.
- One sub-module: `arb_starve_timer`, the saturating `wait_cnt` with clear and increment, which outputs `starved`.

## Test plan
- **Reset:** `reset = 0` with both reqs high for 3 cycles → all outputs 0. Release reset → first cycle `c_gnt = 1`.
- **CPU read:** `c_addr = 32'h0010_0040`, `c_op = 010`, `m_rdata = 32'hDEAD_BEEF` → `m_addr = 32'h0000_0040` in cycle N; `c_rvalid = 1`, `c_rdata = 32'hDEAD_BEEF` in N+1; `v_rvalid = 0`.
- **Starvation:** CPU and fetcher both request continuously with `STARVE_LIMIT = 8` → `c_gnt` for 8 cycles, then `v_gnt` in cycle 9, then `c_gnt` resumes. This repeats every 9 cycles.
- **Out of segment:** CPU write to `32'h0020_0000` → `m_we = 0` throughout; `c_err = 1` and `c_rvalid = 0` in N+1. A fetcher read to the same address → `v_rvalid = v_err = 1`, `v_rdata = 0`.
- **Back-to-back:** CPU read, fetcher read, CPU write in consecutive cycles → `busy` high for cycles N+1 and N+2; `c_rvalid` at N+1, `v_rvalid` at N+2; no pulse at N+3.
- **Reset mid-operation:** read granted at N, `reset = 0` at N+1 → no `rvalid` in N+1 or later.
